// File: rtl/gtp_frame_parser.sv
// Recovers header/length/checksum framed packets from the GTP RX word stream
// and forwards payload as AXI-Stream. Optional trailer checksum: GTP_FRAME_CSUM_EN.
module gtp_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 256
) (
  input  logic        core_clk,
  input  logic        reset,
  input  logic [31:0] gt2port_tdata,
  input  logic        gt2port_tvalid,
  output logic        gt2port_tready,
  input  logic        gt2port_tlast,
  output logic [31:0] pld_tdata,
  output logic        pld_tvalid,
  input  logic        pld_tready,
  output logic        pld_tlast,
  output logic [7:0]  pld_tuser,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

`ifdef GTP_FRAME_CSUM_EN
  typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1, TRAILER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1} state_t;
`endif

  state_t      state, next_state;
  logic [7:0]  type_q;
  logic [15:0] len_q;
  logic [15:0] cnt;
  logic        accept;
  logic        hdr_ok;
  logic        last_word;
  logic        unused_tlast;
`ifdef GTP_FRAME_CSUM_EN
  logic [31:0] csum;
`endif

  // Framing is in-band; the FIFO's tlast is tied high upstream.
  assign unused_tlast = gt2port_tlast;

  assign gt2port_tready = (state != PAYLOAD) || !pld_tvalid || pld_tready;
  assign accept         = gt2port_tvalid && gt2port_tready;
  assign hdr_ok         = (gt2port_tdata[31:24] == SYNC_BYTE) &&
                          (gt2port_tdata[15:0] != '0) &&
                          (gt2port_tdata[15:0] <= MAX_LEN_W);
  assign last_word      = ((cnt + 16'd1) == len_q);

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HUNT:    if (accept && hdr_ok) next_state = PAYLOAD;
`ifdef GTP_FRAME_CSUM_EN
      PAYLOAD: if (accept && last_word) next_state = TRAILER;
      TRAILER: if (accept) next_state = HUNT;
`else
      PAYLOAD: if (accept && last_word) next_state = HUNT;
`endif
      default: next_state = HUNT;
    endcase
  end

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      type_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      pld_tdata  <= '0;
      pld_tvalid <= 1'b0;
      pld_tlast  <= 1'b0;
      pld_tuser  <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      ok_cnt     <= '0;
      err_cnt    <= '0;
`ifdef GTP_FRAME_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      if (pld_tvalid && pld_tready) pld_tvalid <= 1'b0;

      case (state)
        HUNT: if (accept) begin
          if (hdr_ok) begin
            type_q <= gt2port_tdata[23:16];
            len_q  <= gt2port_tdata[15:0];
            cnt    <= '0;
`ifdef GTP_FRAME_CSUM_EN
            csum   <= gt2port_tdata;
`endif
          end else begin
            frame_err <= 1'b1;
            err_code  <= 2'b01;
          end
        end
        PAYLOAD: if (accept) begin
          // Accept here implies the output register is empty or draining this cycle.
          pld_tdata  <= gt2port_tdata;
          pld_tvalid <= 1'b1;
          pld_tlast  <= last_word;
          pld_tuser  <= type_q;
          cnt        <= cnt + 16'd1;
`ifdef GTP_FRAME_CSUM_EN
          csum       <= csum ^ gt2port_tdata;
`else
          if (last_word) frame_ok <= 1'b1;
`endif
        end
`ifdef GTP_FRAME_CSUM_EN
        TRAILER: if (accept) begin
          if (gt2port_tdata == csum) begin
            frame_ok <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            err_code  <= 2'b10;
          end
        end
`endif
        default: ;
      endcase

      if (frame_ok && (ok_cnt != '1))   ok_cnt  <= ok_cnt + 16'd1;
      if (frame_err && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
